// File: rtl/hex_marquee.sv
// hex_marquee: scrolling-message driver for NUM_DIGITS common-anode 7-segment
// digits. Holds a writable message buffer and rotates it across the digits
// once per prescaler tick (or per single-step while paused), left or right.
// All outputs are registered. HEX follows pos and the buffer one cycle later.
module hex_marquee #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH  = 16,
  parameter int TICK_COUNT = 50_000_000,
  parameter int AW         = $clog2(MSG_DEPTH)
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [4:0]              wr_data,
  input  logic [AW:0]             msg_len,
  input  logic                    dir,
  input  logic                    run,
  input  logic                    step,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [AW-1:0]           pos,
  output logic                    tick
);

  localparam int CW = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
  // Display index width: must hold (MSG_DEPTH-1) + (NUM_DIGITS-1) <= 38.
  localparam int VW = AW + 4;
  // Worst case for the modulo reduction is L=1 with the largest index sum.
  localparam int RED_ITERS = MSG_DEPTH + NUM_DIGITS - 2;
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(MSG_DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_COUNT - 1);

  logic [CW-1:0] count;
  logic [4:0]    msg_buf [MSG_DEPTH];
  logic [AW:0]   eff_len;
  logic [AW:0]   len_m1;
  logic          advance;
  logic          shrink;
  logic [AW-1:0] pos_next;
  logic [7*NUM_DIGITS-1:0] hex_next;

  // Active-low a..g pattern for a character code; codes 16..31 are blank.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] seg;
    seg = 7'b1111111;
    if (!code[4]) begin
      case (code[3:0])
        4'h0: seg = 7'b0000001;
        4'h1: seg = 7'b1001111;
        4'h2: seg = 7'b0010010;
        4'h3: seg = 7'b0000110;
        4'h4: seg = 7'b1001100;
        4'h5: seg = 7'b0100100;
        4'h6: seg = 7'b0100000;
        4'h7: seg = 7'b0001111;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0001100;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b1100000;
        4'hC: seg = 7'b0110001;
        4'hD: seg = 7'b1000010;
        4'hE: seg = 7'b0110000;
        default: seg = 7'b0111000;
      endcase
    end
    return seg;
  endfunction

  // Effective message length: clamp msg_len into 1..MSG_DEPTH.
  always_comb begin
    eff_len = msg_len;
    if (msg_len == '0) begin
      eff_len = LEN_ONE;
    end else if (msg_len > LEN_MAX) begin
      eff_len = LEN_MAX;
    end
    len_m1 = eff_len - LEN_ONE;
  end

  // Advance request and the wrapped next position in the chosen direction.
  always_comb begin
    advance  = run ? (count == CNT_LAST) : step;
    shrink   = ({1'b0, pos} >= eff_len);
    pos_next = pos;
    if (advance) begin
      if (!dir) begin
        pos_next = (pos == len_m1[AW-1:0]) ? '0 : pos + AW'(1);
      end else begin
        pos_next = (pos == '0) ? len_m1[AW-1:0] : pos - AW'(1);
      end
    end
  end

  // Prescaler, scroll position and tick pulse. A shrunk length forces pos to 0
  // and wins over any advance in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      count <= '0;
      pos   <= '0;
      tick  <= 1'b0;
    end else begin
      if (run) begin
        count <= (count == CNT_LAST) ? '0 : count + CW'(1);
      end
      if (shrink) begin
        pos  <= '0;
        tick <= 1'b0;
      end else begin
        pos  <= pos_next;
        tick <= advance;
      end
    end
  end

  // Message buffer: reset fills it with blanks; out-of-range writes are dropped.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_buf[i] <= 5'd16;
      end
    end else if (wr_en && ({1'b0, wr_addr} < LEN_MAX)) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  // Per-digit buffer lookup. The index (pos + offset) mod L is reduced by
  // repeated conditional subtraction, enough rounds to cover L=1 and a
  // transiently out-of-range pos, so no divider is needed.
  always_comb begin
    logic [VW-1:0] v;
    v        = '0;
    hex_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      v = VW'(pos) + VW'(NUM_DIGITS - 1 - k);
      for (int i = 0; i < RED_ITERS; i++) begin
        if (v >= VW'(eff_len)) begin
          v = v - VW'(eff_len);
        end
      end
      hex_next[7*k +: 7] = glyph(msg_buf[v[AW-1:0]]);
    end
  end

  // Registered segment outputs, all dark in reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      HEX <= '1;
    end else begin
      HEX <= hex_next;
    end
  end

endmodule

// File: tb/tb_hex_marquee.sv
// tb_hex_marquee: directed steps followed by random stimulus, every cycle
// checked against an arithmetic reference model of the marquee.
module tb_hex_marquee;

  localparam int NUM_DIGITS = 4;
  localparam int MSG_DEPTH  = 12;
  localparam int TICK_COUNT = 4;
  localparam int AW         = $clog2(MSG_DEPTH);
  localparam int HW         = 7 * NUM_DIGITS;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [4:0]    wr_data = '0;
  logic [AW:0]   msg_len = '0;
  logic          dir = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [HW-1:0] hex;
  logic [AW-1:0] pos;
  logic          tick;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_count;
  int            m_pos;
  bit            m_tick;
  logic [HW-1:0] m_hex;
  int            m_buf [MSG_DEPTH];

  hex_marquee #(
    .NUM_DIGITS(NUM_DIGITS),
    .MSG_DEPTH (MSG_DEPTH),
    .TICK_COUNT(TICK_COUNT)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .msg_len (msg_len),
    .dir     (dir),
    .run     (run),
    .step    (step),
    .HEX     (hex),
    .pos     (pos),
    .tick    (tick)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_of(int c);
    if (c >= 16) return 7'h7f;
    return GLYPH[c];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs and model state, then compare.
  task automatic cyc();
    int L, n_pos, n_count, idx;
    bit n_tick, adv;
    logic [HW-1:0] n_hex;
    L = (msg_len == 0) ? 1 : ((int'(msg_len) > MSG_DEPTH) ? MSG_DEPTH : int'(msg_len));
    n_hex = '1;
    if (!resetn) begin
      n_count = 0;
      n_pos   = 0;
      n_tick  = 0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        idx = (m_pos + NUM_DIGITS - 1 - k) % L;
        n_hex[7*k +: 7] = glyph_of(m_buf[idx]);
      end
      adv     = run ? (m_count == TICK_COUNT - 1) : step;
      n_count = run ? (m_count + 1) % TICK_COUNT : m_count;
      if (m_pos >= L) begin
        n_pos  = 0;
        n_tick = 0;
      end else if (adv) begin
        n_pos  = dir ? (m_pos + L - 1) % L : (m_pos + 1) % L;
        n_tick = 1;
      end else begin
        n_pos  = m_pos;
        n_tick = 0;
      end
    end
    @(posedge clk);
    #1;
    if (!resetn) begin
      for (int i = 0; i < MSG_DEPTH; i++) m_buf[i] = 16;
    end else if (wr_en && int'(wr_addr) < MSG_DEPTH) begin
      m_buf[wr_addr] = int'(wr_data);
    end
    m_count = n_count;
    m_pos   = n_pos;
    m_tick  = n_tick;
    m_hex   = n_hex;
    check("pos", 32'(pos), 32'(m_pos));
    check("tick", 32'(tick), 32'(m_tick));
    check("hex", 32'(hex), 32'(m_hex));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = 5'(d);
    cyc();
    wr_en   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MSG_DEPTH; i++) m_buf[i] = 16;
    m_count = 0;
    m_pos   = 0;
    m_tick  = 0;
    m_hex   = '1;

    // Reset held with run=1: nothing moves, display dark.
    resetn = 1'b0;
    run    = 1'b1;
    cycles(10);
    check("reset_hex", 32'(hex), 32'(28'hfffffff));
    check("reset_pos", 32'(pos), 32'd0);

    // Load d E 0 F, L=4, paused.
    resetn  = 1'b1;
    run     = 1'b0;
    msg_len = 5'd4;
    dir     = 1'b0;
    write(0, 13);
    write(1, 14);
    write(2, 0);
    write(3, 15);
    cyc();
    check("load_hex", 32'(hex), 32'({GLYPH[13], GLYPH[14], GLYPH[0], GLYPH[15]}));

    // Scroll left: first advance after TICK_COUNT cycles.
    run = 1'b1;
    cycles(4);
    check("first_adv_pos", 32'(pos), 32'd1);
    check("first_adv_tick", 32'(tick), 32'd1);
    cyc();
    check("scroll_hex", 32'(hex), 32'({GLYPH[14], GLYPH[0], GLYPH[15], GLYPH[13]}));
    cycles(11);

    // Scroll right through the wrap at 0.
    dir = 1'b1;
    cycles(12);

    // Pause mid-count, two single steps, then step held while running.
    cycles(2);
    run = 1'b0;
    cycles(2);
    step = 1'b1; cyc(); step = 1'b0; cyc();
    step = 1'b1; cyc(); step = 1'b0; cyc();
    run  = 1'b1;
    step = 1'b1;
    cycles(9);
    step = 1'b0;

    // Short message 1 2 3 repeats across four digits.
    resetn = 1'b0;
    cyc();
    resetn  = 1'b1;
    run     = 1'b0;
    dir     = 1'b0;
    msg_len = 5'd3;
    write(0, 1);
    write(1, 2);
    write(2, 3);
    cyc();
    check("repeat_hex", 32'(hex), 32'({GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[1]}));
    step = 1'b1; cyc(); cyc(); step = 1'b0;
    check("step_to_2", 32'(pos), 32'd2);
    msg_len = 5'd2;
    cyc();
    check("shrink_pos", 32'(pos), 32'd0);
    check("shrink_tick", 32'(tick), 32'd0);
    cyc();

    // Blank written in the same cycle as an advance, then an out-of-range write.
    msg_len = 5'd3;
    step    = 1'b1;
    wr_en   = 1'b1;
    wr_addr = AW'(1);
    wr_data = 5'd16;
    cyc();
    step  = 1'b0;
    wr_en = 1'b0;
    cyc();
    check("wr_adv_hex", 32'(hex), 32'({7'h7f, GLYPH[3], GLYPH[1], 7'h7f}));
    write(MSG_DEPTH, 0);
    cycles(2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      resetn  = ($urandom_range(0, 60) != 0);
      run     = ($urandom_range(0, 3) != 0);
      step    = $urandom_range(0, 1);
      dir     = ($urandom_range(0, 15) == 0) ? ~dir : dir;
      if ($urandom_range(0, 20) == 0) msg_len = ($urandom_range(0, 31));
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_marquee.md
Name: hex_marquee

Overview:
- Parametrised scrolling-message driver for NUM_DIGITS common-anode 7-segment displays.
- Holds a writable message buffer of up to MSG_DEPTH character codes.
- Rotates the message across the digits once per prescaled tick, left or right.
- Supports run/pause and single-step.
- Sits between board switch/key logic and the HEX outputs; replaces fixed-length, fixed-direction 4-digit rotators.

Parameters:
- NUM_DIGITS, 4, number of 7-segment digits driven (1..8)
- MSG_DEPTH, 16, message buffer entries (2..32, need not be a power of 2)
- TICK_COUNT, 50_000_000, CLOCK_50 cycles per scroll step (>=2)
- AW, clog2(MSG_DEPTH), address/position width (derived)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- wr_en  in  1  write strobe for message buffer
- wr_addr  in  AW  buffer entry to write; writes with wr_addr>=MSG_DEPTH are ignored
- wr_data  in  5  character code: 0..15 = hex glyph 0-F; 16..31 = blank
- msg_len  in  AW+1  active message length; 0 treated as 1, >MSG_DEPTH treated as MSG_DEPTH
- dir  in  1  0 = scroll left (pos increments), 1 = scroll right (pos decrements)
- run  in  1  1 = auto-scroll on prescaler tick, 0 = paused
- step  in  1  single-cycle advance request, honoured only while run=0
- HEX  out  7*NUM_DIGITS  active-low segments; digit k at bits [7k+6:7k], bit 7k = seg g … bit 7k+6 = seg a; digit 0 = rightmost
- pos  out  AW  current scroll position
- tick  out  1  one-cycle pulse on every position advance

Behaviour:
- Reset (resetn=0 at a clock edge): count=0, pos=0, tick=0, every buffer entry = 16 (blank), HEX = all ones. Reset mid-scroll discards the message.
- Effective length L = clamp(msg_len, 1, MSG_DEPTH), evaluated every cycle.
- Prescaler: while run=1, count increments each cycle.
  - At count==TICK_COUNT-1, count←0 and an advance occurs.
  - While run=0, count holds its value. Resuming continues from the held count, not from 0.
- Advance sources (at most one advance per cycle):
  - prescaler wrap while run=1
  - step=1 while run=0
  - step while run=1 is ignored
- Advance with dir=0: pos ← (pos==L-1) ? 0 : pos+1.
- Advance with dir=1: pos ← (pos==0) ? L-1 : pos-1.
- tick=1 for exactly the cycle after an advance is registered (registered pulse aligned with the new pos).
- Length shrink: if pos>=L in any cycle, pos←0 on the next edge. This takes priority over an advance; tick is not asserted.
- Display mapping: digit k shows buffer[(pos + NUM_DIGITS-1-k) mod L].
  - True modulo: for NUM_DIGITS>L the message repeats.
  - Implement as bounded conditional subtraction; no divider.
- Glyph table (segments a..g, active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111
- HEX is registered: it reflects pos and buffer contents with 1 cycle latency.
- Write port: buffer[wr_addr]←wr_data at the edge. Visible on HEX the cycle after the write is registered (2 edges after wr_en sampled).
- Write and advance in the same cycle: both take effect; the following HEX uses the new pos and new data.
- Writes beyond L are allowed and become visible once msg_len grows.

Test Plan:
- Reset → HEX all ones, pos=0, tick=0; hold 10 cycles with run=1 and resetn=0 → pos stays 0.
- TICK_COUNT=4, load 13,14,0,15, msg_len=4, dir=0, run=1 → pos 1,2,3,0 every 4 cycles; tick one cycle each; HEX digit3..0 sequence d E 0 F → E 0 F d.
- dir=1 from pos=0, L=4 → next pos=3; then 2; single tick per step.
- run=0, count mid-way, pulse step twice → two advances; run=1 with step held high → step ignored; prescaler resumes from held count.
- NUM_DIGITS=4, L=3 (1,2,3) → HEX shows 1 2 3 1; msg_len set to 2 while pos=2 → pos=0 next cycle, no tick.
- Write wr_addr=1 data=16 simultaneous with advance → blank appears at the correct digit exactly 2 edges later; wr_addr=MSG_DEPTH → no change.
